// File: rtl/output_io.sv
// Output pad cell: either a combinational pass-through or a registered data/enable
// path whose driver stays on for a few "park" cycles after the enable drops.
module output_io #(
    parameter string       MODE     = "out_buff",
    parameter logic        INIT_VAL = 1'b0,
    parameter int unsigned PARK_CYC = 1
) (
    input  logic IQC,
    input  logic QRT,
    input  logic OQI,
    input  logic OQE,
    input  logic OCE,
    output logic F2A,
    output logic F2A_EN,
    output logic PARKED
);

    localparam bit          IS_REG  = (MODE == "out_reg");
    localparam logic [1:0]  PC_LOAD = 2'(PARK_CYC - 1);

    typedef enum logic [1:0] {
        HIZ   = 2'd0,
        DRIVE = 2'd1,
        PARK  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_pc;
    logic [1:0] w_pc_nxt;
    logic       r_dq;
    logic       w_dq_nxt;
    logic       r_eq;
    logic       w_eq_nxt;

    // State, park counter and data/enable registers
    always_ff @(posedge IQC or negedge QRT) begin
        if (!QRT) begin
            r_state <= HIZ;
            r_pc    <= 2'd0;
            r_dq    <= INIT_VAL;
            r_eq    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_dq    <= w_dq_nxt;
            r_eq    <= w_eq_nxt;
        end
    end

    // Transitions follow the value being loaded into eq on the same edge
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_dq_nxt    = r_dq;
        w_eq_nxt    = r_eq;
        if (IS_REG) begin
            if (OCE) begin
                w_eq_nxt = OQE;
            end
            unique case (r_state)
                HIZ: begin
                    if (OCE && OQE) begin
                        w_state_nxt = DRIVE;
                    end
                end
                DRIVE: begin
                    if (OCE && !OQE) begin
                        if (PARK_CYC > 0) begin
                            w_state_nxt = PARK;
                            w_pc_nxt    = PC_LOAD;
                        end else begin
                            w_state_nxt = HIZ;
                        end
                    end
                end
                PARK: begin
                    if (OCE && OQE) begin
                        w_state_nxt = DRIVE;
                        w_pc_nxt    = 2'd0;
                    end else if (r_pc == 2'd0) begin
                        w_state_nxt = HIZ;
                    end else begin
                        w_pc_nxt = r_pc - 2'd1;
                    end
                end
                default: begin
                    w_state_nxt = HIZ;
                    w_pc_nxt    = 2'd0;
                end
            endcase
            // Last driven value is held from the edge entering PARK until PARK is left
            if (OCE && (r_state != PARK) && (w_state_nxt != PARK)) begin
                w_dq_nxt = OQI;
            end
        end
    end

    assign F2A    = IS_REG ? r_dq : OQI;
    assign F2A_EN = IS_REG ? (r_state != HIZ) : (OQE & QRT);
    assign PARKED = IS_REG && (r_state == PARK);

endmodule

// File: tb/tb_output_io.sv
// Directed bench for output_io: buffered and registered modes with several park lengths.
module tb_output_io;

    logic clk;
    logic rst_n;
    logic oqi;
    logic oqe;
    logic oce;

    logic buf_f2a,  buf_en,  buf_pk;
    logic bad_f2a,  bad_en,  bad_pk;
    logic r1_f2a,   r1_en,   r1_pk;
    logic r3_f2a,   r3_en,   r3_pk;
    logic r0_f2a,   r0_en,   r0_pk;
    logic i1_f2a,   i1_en,   i1_pk;

    int n_chk;
    int n_err;

    output_io u_buf (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(buf_f2a), .F2A_EN(buf_en), .PARKED(buf_pk)
    );

    output_io #(.MODE("junk")) u_bad (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(bad_f2a), .F2A_EN(bad_en), .PARKED(bad_pk)
    );

    output_io #(.MODE("out_reg"), .INIT_VAL(1'b0), .PARK_CYC(1)) u_reg1 (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(r1_f2a), .F2A_EN(r1_en), .PARKED(r1_pk)
    );

    output_io #(.MODE("out_reg"), .INIT_VAL(1'b0), .PARK_CYC(3)) u_reg3 (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(r3_f2a), .F2A_EN(r3_en), .PARKED(r3_pk)
    );

    output_io #(.MODE("out_reg"), .INIT_VAL(1'b0), .PARK_CYC(0)) u_reg0 (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(r0_f2a), .F2A_EN(r0_en), .PARKED(r0_pk)
    );

    output_io #(.MODE("out_reg"), .INIT_VAL(1'b1), .PARK_CYC(1)) u_init1 (
        .IQC(clk), .QRT(rst_n), .OQI(oqi), .OQE(oqe), .OCE(oce),
        .F2A(i1_f2a), .F2A_EN(i1_en), .PARKED(i1_pk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        oce   = 1'b1;
        oqe   = 1'b0;
        oqi   = 1'b0;
        #12;

        // reset values
        check_bit("rst r1 f2a", r1_f2a, 1'b0);
        check_bit("rst r1 en",  r1_en,  1'b0);
        check_bit("rst r1 pk",  r1_pk,  1'b0);
        check_bit("rst i1 f2a", i1_f2a, 1'b1);
        check_bit("rst i1 en",  i1_en,  1'b0);
        rst_n = 1'b1;

        // cycle 0: start driving a 1
        oqi = 1'b1;
        oqe = 1'b1;
        step();
        check_bit("c1 r1 f2a", r1_f2a, 1'b1);
        check_bit("c1 r1 en",  r1_en,  1'b1);
        check_bit("c1 r1 pk",  r1_pk,  1'b0);
        step();
        step();
        check_bit("c3 r1 en", r1_en, 1'b1);

        // cycle 3: drop enable and data
        oqe = 1'b0;
        oqi = 1'b0;
        step();
        check_bit("c4 r1 f2a", r1_f2a, 1'b1);
        check_bit("c4 r1 en",  r1_en,  1'b1);
        check_bit("c4 r1 pk",  r1_pk,  1'b1);
        check_bit("c4 r3 pk",  r3_pk,  1'b1);
        check_bit("c4 r0 en",  r0_en,  1'b0);
        check_bit("c4 r0 pk",  r0_pk,  1'b0);
        check_bit("c4 r0 f2a", r0_f2a, 1'b0);
        step();
        check_bit("c5 r1 en",  r1_en,  1'b0);
        check_bit("c5 r1 pk",  r1_pk,  1'b0);
        check_bit("c5 r1 f2a", r1_f2a, 1'b1);
        check_bit("c5 r3 pk",  r3_pk,  1'b1);
        check_bit("c5 r3 en",  r3_en,  1'b1);
        check_bit("c5 r0 pk",  r0_pk,  1'b0);

        // second PARK cycle of the 3-cycle instance: re-enable
        oqe = 1'b1;
        step();
        check_bit("c6 r3 en",  r3_en,  1'b1);
        check_bit("c6 r3 pk",  r3_pk,  1'b0);
        check_bit("c6 r3 f2a", r3_f2a, 1'b1);
        check_bit("c6 r1 f2a", r1_f2a, 1'b0);
        check_bit("c6 r1 en",  r1_en,  1'b1);

        // drop again, then freeze eq with OCE=0: countdown must still finish
        oqe = 1'b0;
        step();
        check_bit("c7 r3 pk", r3_pk, 1'b1);
        check_bit("c7 r1 pk", r1_pk, 1'b1);
        oce = 1'b0;
        oqe = 1'b1;
        step();
        check_bit("c8 r3 pk", r3_pk, 1'b1);
        check_bit("c8 r1 en", r1_en, 1'b0);
        step();
        check_bit("c9 r3 pk", r3_pk, 1'b1);
        step();
        check_bit("c10 r3 en", r3_en, 1'b0);
        check_bit("c10 r3 pk", r3_pk, 1'b0);

        // OCE=0 hold while inputs toggle
        oce = 1'b1;
        oqe = 1'b1;
        oqi = 1'b1;
        step();
        check_bit("hold pre f2a", r1_f2a, 1'b1);
        check_bit("hold pre en",  r1_en,  1'b1);
        oce = 1'b0;
        for (int i = 0; i < 4; i++) begin
            oqi = logic'(i % 2);
            oqe = logic'(i % 2);
            step();
            check_bit("hold f2a", r1_f2a, 1'b1);
            check_bit("hold en",  r1_en,  1'b1);
            check_bit("hold pk",  r1_pk,  1'b0);
        end
        oqi = 1'b0;
        oqe = 1'b1;
        oce = 1'b1;
        step();
        check_bit("reload f2a", r1_f2a, 1'b0);
        check_bit("reload en",  r1_en,  1'b1);

        // async reset mid-DRIVE with dq=0 and INIT_VAL=1
        check_bit("i1 pre f2a", i1_f2a, 1'b0);
        check_bit("i1 pre en",  i1_en,  1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_bit("arst i1 en",  i1_en,  1'b0);
        check_bit("arst i1 f2a", i1_f2a, 1'b1);
        check_bit("arst i1 pk",  i1_pk,  1'b0);
        check_bit("arst r3 en",  r3_en,  1'b0);
        #1;
        rst_n = 1'b1;
        #1;
        check_bit("rel i1 en", i1_en, 1'b0);
        oqi = 1'b0;
        oqe = 1'b1;
        step();
        check_bit("resume i1 en",  i1_en,  1'b1);
        check_bit("resume i1 f2a", i1_f2a, 1'b0);

        // combinational pass-through (legal and illegal MODE strings)
        oce = 1'b0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] pat;
            pat = 2'(v);
            oqi = pat[0];
            oqe = pat[1];
            #1;
            check_bit("buf f2a", buf_f2a, pat[0]);
            check_bit("buf en",  buf_en,  pat[1]);
            check_bit("buf pk",  buf_pk,  1'b0);
            check_bit("bad f2a", bad_f2a, pat[0]);
            check_bit("bad en",  bad_en,  pat[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/output_io.md
OUTPUT_IO -- requirements
Module: output_io

Interface
REQ-001 SHALL have parameter MODE, default "out_buff": selects "out_buff" (combinational pass) or "out_reg" (registered data/enable with turn-off parking).
REQ-002 SHALL have parameter INIT_VAL, default 1'b0: reset value of the data register.
REQ-003 SHALL have parameter PARK_CYC, default 1: cycles the pad keeps driving after enable drops in out_reg mode (legal 0-3).
REQ-004 SHALL have port IQC, input, 1 bit: the single clock, rising edge.
REQ-005 SHALL have port QRT, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port OQI, input, 1 bit: output data from fabric.
REQ-007 SHALL have port OQE, input, 1 bit: output enable from fabric, 1 = drive the pad.
REQ-008 SHALL have port OCE, input, 1 bit: register clock enable, 1 = load, 0 = hold.
REQ-009 SHALL have port F2A, output, 1 bit: data driven toward the pad.
REQ-010 SHALL have port F2A_EN, output, 1 bit: pad driver enable.
REQ-011 SHALL have port PARKED, output, 1 bit: status, high while in state PARK.

Function
REQ-012 In out_buff mode: F2A = OQI and F2A_EN = OQE combinationally; OCE is ignored; registers stay at reset values; PARKED = 0.
REQ-013 In out_reg mode, on each IQC rise with OCE=1: data register dq <= OQI and enable register eq <= OQE; with OCE=0 both hold.
REQ-014 In out_reg mode, F2A SHALL equal dq: one-cycle latency from OQI.
REQ-015 FSM states: HIZ (F2A_EN=0), DRIVE (F2A_EN=1), PARK (F2A_EN=1, PARKED=1). F2A_EN and PARKED decode from registered state only, so they are glitch-free.
REQ-016 HIZ -> DRIVE on the clock edge loading eq=1 (OCE=1, OQE=1). F2A_EN therefore rises one cycle after OQE is sampled.
REQ-017 DRIVE -> PARK on the edge loading eq=0 when PARK_CYC>0. PARK counter pc (2 bits) loads PARK_CYC-1 on entry.
REQ-018 DRIVE -> HIZ directly on the edge loading eq=0 when PARK_CYC=0.
REQ-019 In PARK, dq is frozen regardless of OCE/OQI, so the last driven value persists. Each cycle pc decrements; at pc=0 the next edge goes to HIZ.
REQ-020 PARK -> DRIVE on an edge that loads eq=1 while in PARK. This takes priority over the count, and pc is cleared.
REQ-021 In HIZ, dq keeps updating per REQ-013, so the data is valid when drive starts.
REQ-022 OCE=0 freezes eq, so state transitions driven by eq stall. The PARK countdown still proceeds.
REQ-023 Any MODE other than the two legal strings behaves as out_buff.

Reset
REQ-024 QRT=0 SHALL asynchronously force: dq=INIT_VAL, eq=0, state=HIZ, pc=0, F2A_EN=0, PARKED=0, with F2A=INIT_VAL in out_reg mode.
REQ-025 QRT asserted mid-DRIVE or mid-PARK SHALL drop F2A_EN within the same cycle, without waiting for a clock edge.
REQ-026 After QRT deasserts, the first IQC rise SHALL resume normal loading per REQ-013.

Verification
REQ-027 out_buff: toggle OQI 0/1 with OQE=1 -> F2A follows with zero cycles of delay and F2A_EN=1; set OQE=0 -> F2A_EN=0 immediately.
REQ-028 out_reg, PARK_CYC=1, OCE=1: OQE=1,OQI=1 at cycle 0 -> F2A_EN=1, F2A=1 from cycle 1. Then OQE=0,OQI=0 at cycle 3 -> F2A_EN=1, PARKED=1, F2A=1 in cycle 4, and F2A_EN=0 from cycle 5.
REQ-029 out_reg, PARK_CYC=3: drop OQE, then reassert OQE in the 2nd PARK cycle -> returns to DRIVE with no F2A_EN low cycle, and PARKED=0 the following cycle.
REQ-030 out_reg, PARK_CYC=0: drop OQE -> F2A_EN=0 one cycle later, PARKED never 1.
REQ-031 out_reg: hold OCE=0 for 4 cycles while toggling OQI/OQE -> F2A and F2A_EN unchanged. Raising OCE loads the current values on the next edge.
REQ-032 out_reg, INIT_VAL=1: pulse QRT low between clock edges while in DRIVE with dq=0 -> F2A_EN=0 and F2A=1 immediately; after release the state is HIZ.
